// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch program counter with prioritised redirects and stall-safe pending redirect
module pc_gen #(
    parameter int          WIDTH     = 32,
    parameter logic [31:0] RESET_VEC = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
    parameter int          STEP      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             denPC,
    input  logic             exc,
    input  logic             eret,
    input  logic [WIDTH-1:0] epc,
    input  logic             jmp,
    input  logic [WIDTH-1:0] jmpTarget,
    input  logic             brTaken,
    input  logic [WIDTH-1:0] brTarget,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pcPlus,
    output logic             pendValid,
    output logic             misalign
);

    localparam logic [WIDTH-1:0] RST_V  = WIDTH'(RESET_VEC);
    localparam logic [WIDTH-1:0] EXC_V  = WIDTH'(EXC_VEC);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    logic [WIDTH-1:0] pc_r, pc_next;
    logic [WIDTH-1:0] pend_target, pend_target_next;
    logic             pend_valid, pend_valid_next;
    logic             pend_exc, pend_exc_next;
    logic [WIDTH-1:0] t_new;
    logic             any_req;

    assign pc        = pc_r;
    assign pcPlus    = pc_r + STEP_W;
    assign pendValid = pend_valid;
    assign misalign  = (pc_r[1:0] != 2'b00);

    always_comb begin
        any_req = exc | eret | jmp | brTaken;
        t_new   = pcPlus;
        if (exc)
            t_new = EXC_V;
        else if (eret)
            t_new = epc;
        else if (jmp)
            t_new = jmpTarget;
        else if (brTaken)
            t_new = brTarget;
    end

    always_comb begin
        pc_next          = pc_r;
        pend_target_next = pend_target;
        pend_valid_next  = pend_valid;
        pend_exc_next    = pend_exc;
        if (!denPC) begin
            // A pending redirect belongs to an older instruction, so only exc beats it
            if (exc)
                pc_next = EXC_V;
            else if (pend_valid)
                pc_next = pend_target;
            else if (any_req)
                pc_next = t_new;
            else
                pc_next = pcPlus;
            pend_valid_next = 1'b0;
            pend_exc_next   = 1'b0;
        end else begin
            if (!pend_valid && any_req) begin
                pend_target_next = t_new;
                pend_valid_next  = 1'b1;
                pend_exc_next    = exc;
            end else if (pend_valid && exc && !pend_exc) begin
                pend_target_next = EXC_V;
                pend_exc_next    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r        <= RST_V;
            pend_target <= '0;
            pend_valid  <= 1'b0;
            pend_exc    <= 1'b0;
        end else begin
            pc_r        <= pc_next;
            pend_target <= pend_target_next;
            pend_valid  <= pend_valid_next;
            pend_exc    <= pend_exc_next;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed self-checking bench for pc_gen
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        denPC = 1'b0;
    logic        exc = 1'b0;
    logic        eret = 1'b0;
    logic [31:0] epc = '0;
    logic        jmp = 1'b0;
    logic [31:0] jmpTarget = '0;
    logic        brTaken = 1'b0;
    logic [31:0] brTarget = '0;
    logic [31:0] pc;
    logic [31:0] pcPlus;
    logic        pendValid;
    logic        misalign;

    int tests_run = 0;
    int tests_failed = 0;

    pc_gen dut (
        .clk(clk), .reset(reset), .denPC(denPC), .exc(exc), .eret(eret), .epc(epc),
        .jmp(jmp), .jmpTarget(jmpTarget), .brTaken(brTaken), .brTarget(brTarget),
        .pc(pc), .pcPlus(pcPlus), .pendValid(pendValid), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_req();
        exc = 0; eret = 0; jmp = 0; brTaken = 0;
    endtask

    initial begin
        // asynchronous reset between edges
        #3 reset = 1;
        #1;
        check("rst_pc", pc, 32'h0000_3000);
        check("rst_pv", {31'b0, pendValid}, 32'd0);
        check("rst_plus", pcPlus, 32'h0000_3004);
        @(negedge clk);
        reset = 0;
        tick(); check("run1", pc, 32'h0000_3004); check("run1_plus", pcPlus, 32'h0000_3008);
        tick(); check("run2", pc, 32'h0000_3008);
        tick(); check("run3", pc, 32'h0000_300C); check("run3_plus", pcPlus, 32'h0000_3010);

        // priority
        exc = 1; jmp = 1; jmpTarget = 32'h0000_5000; brTaken = 1; brTarget = 32'h0000_6000;
        tick(); check("prio_exc", pc, 32'h0000_4180);
        exc = 0;
        tick(); check("prio_jmp", pc, 32'h0000_5000);
        eret = 1; epc = 32'h0000_7000;
        tick(); check("prio_eret", pc, 32'h0000_7000);
        clear_req();

        // stalled branch
        jmp = 1; jmpTarget = 32'h0000_3010;
        tick(); check("setup", pc, 32'h0000_3010);
        clear_req();
        denPC = 1; brTaken = 1; brTarget = 32'h0000_3100;
        tick(); check("stall1_pc", pc, 32'h0000_3010); check("stall1_pv", {31'b0, pendValid}, 32'd1);
        brTaken = 0; jmp = 1; jmpTarget = 32'h0000_5000;
        tick(); check("stall2_pc", pc, 32'h0000_3010); check("stall2_pv", {31'b0, pendValid}, 32'd1);
        jmp = 0;
        tick(); check("stall3_pc", pc, 32'h0000_3010);
        denPC = 0;
        tick(); check("unstall_pc", pc, 32'h0000_3100); check("unstall_pv", {31'b0, pendValid}, 32'd0);

        // exception overrides pending branch during stall
        denPC = 1; brTaken = 1; brTarget = 32'h0000_3200;
        tick(); check("excov_pv", {31'b0, pendValid}, 32'd1);
        brTaken = 0; exc = 1;
        tick(); check("excov_hold", pc, 32'h0000_3100);
        exc = 0; denPC = 0;
        tick(); check("excov_pc", pc, 32'h0000_4180);

        // exc on the unstalling edge beats a pending branch
        denPC = 1; brTaken = 1; brTarget = 32'h0000_3300;
        tick();
        brTaken = 0; denPC = 0; exc = 1;
        tick(); check("excun_pc", pc, 32'h0000_4180);
        exc = 0;

        // captured exception is not displaced by a later jump
        denPC = 1; exc = 1;
        tick();
        exc = 0; jmp = 1; jmpTarget = 32'h0000_5000;
        tick();
        jmp = 0; denPC = 0;
        tick(); check("excpend_pc", pc, 32'h0000_4180);

        // pending redirect beats a new request on the unstalling edge
        denPC = 1; brTaken = 1; brTarget = 32'h0000_3400;
        tick();
        brTaken = 0; denPC = 0; jmp = 1; jmpTarget = 32'h0000_5000;
        tick(); check("pendwin_pc", pc, 32'h0000_3400);
        check("pendwin_pv", {31'b0, pendValid}, 32'd0);

        // wrap
        jmpTarget = 32'hFFFF_FFFC;
        tick(); check("wrap_load", pc, 32'hFFFF_FFFC); check("wrap_plus", pcPlus, 32'h0000_0000);
        jmp = 0;
        tick(); check("wrap_pc", pc, 32'h0000_0000);

        // misalign
        jmp = 1; jmpTarget = 32'h0000_3002;
        tick(); check("mis_pc", pc, 32'h0000_3002); check("mis_flag", {31'b0, misalign}, 32'd1);
        jmpTarget = 32'h0000_3008;
        tick(); check("mis_clear", {31'b0, misalign}, 32'd0);
        jmp = 0;

        // reset with a redirect pending
        denPC = 1; brTaken = 1; brTarget = 32'h0000_3500;
        tick(); check("rstmid_pv1", {31'b0, pendValid}, 32'd1);
        brTaken = 0;
        #2 reset = 1;
        #1;
        check("rstmid_pc", pc, 32'h0000_3000);
        check("rstmid_pv", {31'b0, pendValid}, 32'd0);
        @(negedge clk);
        reset = 0; denPC = 0;
        tick(); check("rstmid_run", pc, 32'h0000_3004);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
